fifo_asym_wide_write_narrow_read: RTL and testbench

//  Width-converting FIFO: wide words pushed on the write side, narrow words popped on the read side.

---
 rtl/fifo_asym_wide_write_narrow_read_pkg.sv | 22 ++
 rtl/fifo_asym_wide_write_narrow_read_if.sv | 31 +++
 rtl/fifo_asym_wide_write_narrow_read_ram.sv | 34 +++
 rtl/fifo_asym_wide_write_narrow_read.sv | 100 ++++++++++
 tb/tb_fifo_asym_wide_write_narrow_read.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/fifo_asym_wide_write_narrow_read_pkg.sv
// Shared helpers for the asymmetric wide-write / narrow-read FIFO:
// width and address derivations plus a lane-slice macro.
`define FIFO_ASYM_LANE(word, k, w) word[(k)*(w) +: (w)]

package fifo_asym_pkg;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ratio_of(input int wr_width, input int rd_width);
    return wr_width / rd_width;
  endfunction

  // Wide-side address drops the lane-select bits from the narrow address.
  function automatic int wr_aw_of(input int rd_depth, input int wr_width, input int rd_width);
    return clog2(rd_depth) - clog2(ratio_of(wr_width, rd_width));
  endfunction

endpackage

// File: rtl/fifo_asym_wide_write_narrow_read_if.sv
// Push/pop bus of the width-converting FIFO; master drives requests, slave is the FIFO.
interface fifo_asym_wide_write_narrow_read_if
  import fifo_asym_pkg::*;
#(
   parameter int WR_WIDTH = 32,
   parameter int RD_WIDTH = 8,
   parameter int RD_DEPTH = 4096
);
   localparam int RD_AW = clog2(RD_DEPTH);

   logic                wce;
   logic [WR_WIDTH-1:0] wd;
   logic                full;
   logic                rce;
   logic [RD_WIDTH-1:0] rq;
   logic                rvalid;
   logic                empty;
   logic [RD_AW:0]      level;
   logic                ovf;
   logic                udf;

   modport master (
      output wce, wd, rce,
      input  full, rq, rvalid, empty, level, ovf, udf
   );

   modport slave (
      input  wce, wd, rce,
      output full, rq, rvalid, empty, level, ovf, udf
   );
endinterface

// File: rtl/fifo_asym_wide_write_narrow_read_ram.sv
// Pure asymmetric storage: one wide write of RATIO lanes, one registered narrow read.
module asym_ram_wide_wr_narrow_rd
  import fifo_asym_pkg::*;
#(
   parameter int WR_WIDTH = 32,
   parameter int RD_WIDTH = 8,
   parameter int RD_DEPTH = 4096,
   localparam int RATIO   = ratio_of(WR_WIDTH, RD_WIDTH),
   localparam int RD_AW   = clog2(RD_DEPTH),
   localparam int WR_AW   = wr_aw_of(RD_DEPTH, WR_WIDTH, RD_WIDTH),
   localparam int LANE_AW = clog2(RATIO)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [WR_AW-1:0]    wa,
   input  logic [WR_WIDTH-1:0] wd,
   input  logic                re,
   input  logic [RD_AW-1:0]    ra,
   output logic [RD_WIDTH-1:0] rq
);
   logic [RD_WIDTH-1:0] mem [RD_DEPTH];

   // NOTE: no reset on mem or rq -- a reset branch would stop the array mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < RATIO; k++) begin
            mem[{wa, LANE_AW'(k)}] <= `FIFO_ASYM_LANE(wd, k, RD_WIDTH);
         end
      end
      if (re) begin
         rq <= mem[ra];
      end
   end
endmodule

// File: rtl/fifo_asym_wide_write_narrow_read.sv
// Width-converting FIFO: pointers, level counter, flags and sticky errors around the asymmetric RAM.
module fifo_asym_wide_write_narrow_read
  import fifo_asym_pkg::*;
#(
   parameter int WR_WIDTH = 32,
   parameter int RD_WIDTH = 8,
   parameter int RD_DEPTH = 4096
) (
   input logic                         clk,
   input logic                         rst,
   fifo_asym_wide_write_narrow_read_if.slave bus
);
   localparam int RATIO = ratio_of(WR_WIDTH, RD_WIDTH);
   localparam int RD_AW = clog2(RD_DEPTH);
   localparam int WR_AW = wr_aw_of(RD_DEPTH, WR_WIDTH, RD_WIDTH);
   localparam int LVL_W = RD_AW + 1;

   localparam logic [LVL_W-1:0] LVL_RATIO = LVL_W'(RATIO);
   localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
   localparam logic [LVL_W-1:0] FULL_TH   = LVL_W'(RD_DEPTH - RATIO);

   logic [WR_AW-1:0]    wptr_q, wptr_d;
   logic [RD_AW-1:0]    rptr_q, rptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                rvalid_q, rvalid_d;
   logic                ovf_q, ovf_d;
   logic                udf_q, udf_d;
   logic                rq_clr_q, rq_clr_d;
   logic                full, empty, push_acc, pop_acc;
   logic [RD_WIDTH-1:0] ram_rq;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      full     = (level_q > FULL_TH);
      empty    = (level_q == '0);
      push_acc = bus.wce && !full;
      pop_acc  = bus.rce && !empty;

      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      level_d  = level_q;
      if (push_acc) begin
         wptr_d  = wptr_q + WR_AW'(1);
         level_d = level_d + LVL_RATIO;
      end
      if (pop_acc) begin
         rptr_d  = rptr_q + RD_AW'(1);
         level_d = level_d - LVL_ONE;
      end

      rvalid_d = pop_acc;
      ovf_d    = ovf_q || (bus.wce && full);
      udf_d    = udf_q || (bus.rce && empty);
      // rq must read 0 after reset until the first pop refreshes the RAM output register.
      rq_clr_d = rq_clr_q && !pop_acc;
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         rvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rq_clr_q <= 1'b1;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         rvalid_q <= rvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         rq_clr_q <= rq_clr_d;
      end
   end

   asym_ram_wide_wr_narrow_rd #(
      .WR_WIDTH (WR_WIDTH),
      .RD_WIDTH (RD_WIDTH),
      .RD_DEPTH (RD_DEPTH)
   ) u_ram (
      .clk (clk),
      .we  (push_acc && !rst),
      .wa  (wptr_q),
      .wd  (bus.wd),
      .re  (pop_acc),
      .ra  (rptr_q),
      .rq  (ram_rq)
   );

   assign bus.full   = full;
   assign bus.empty  = empty;
   assign bus.level  = level_q;
   assign bus.rvalid = rvalid_q;
   assign bus.ovf    = ovf_q;
   assign bus.udf    = udf_q;
   assign bus.rq     = rq_clr_q ? '0 : ram_rq;
endmodule

// File: tb/tb_fifo_asym_wide_write_narrow_read.sv
// Scoreboard bench for the width-converting FIFO: bytes queued on push, compared on pop.
module tb_fifo_asym_wide_write_narrow_read;
   localparam int WR_WIDTH = 32;
   localparam int RD_WIDTH = 8;
   localparam int RD_DEPTH = 4096;
   localparam int RATIO    = WR_WIDTH / RD_WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_asym_wide_write_narrow_read_if #(
      .WR_WIDTH (WR_WIDTH), .RD_WIDTH (RD_WIDTH), .RD_DEPTH (RD_DEPTH)
   ) bus ();

   fifo_asym_wide_write_narrow_read #(
      .WR_WIDTH (WR_WIDTH), .RD_WIDTH (RD_WIDTH), .RD_DEPTH (RD_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb [$];
   int         lvl_m    = 0;
   logic       ovf_m    = 1'b0;
   logic       udf_m    = 1'b0;
   logic       rvalid_m = 1'b0;
   logic [7:0] rq_m     = 8'h00;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("level",  32'(bus.level),  32'(lvl_m));
      check("full",   32'(bus.full),   32'(lvl_m > RD_DEPTH - RATIO));
      check("empty",  32'(bus.empty),  32'(lvl_m == 0));
      check("rvalid", 32'(bus.rvalid), 32'(rvalid_m));
      check("rq",     32'(bus.rq),     32'(rq_m));
      check("ovf",    32'(bus.ovf),    32'(ovf_m));
      check("udf",    32'(bus.udf),    32'(udf_m));
   endtask

   // One clock cycle of stimulus; the model advances from its own pre-edge state.
   task automatic step(input logic w, input logic [31:0] d, input logic r);
      logic m_full, m_empty, pa, ra;
      bus.wce = w;
      bus.wd  = d;
      bus.rce = r;
      m_full  = (lvl_m > RD_DEPTH - RATIO);
      m_empty = (lvl_m == 0);
      pa      = w && !m_full;
      ra      = r && !m_empty;
      @(posedge clk);
      #1;
      if (w && m_full)  ovf_m = 1'b1;
      if (r && m_empty) udf_m = 1'b1;
      if (ra) rq_m = sb.pop_front();
      if (pa) for (int k = 0; k < RATIO; k++) sb.push_back(d[k*8 +: 8]);
      lvl_m    = lvl_m + (pa ? RATIO : 0) - (ra ? 1 : 0);
      rvalid_m = ra;
      bus.wce  = 1'b0;
      bus.rce  = 1'b0;
      check_all();
   endtask

   task automatic do_reset(input logic w, input logic r);
      rst     = 1'b1;
      bus.wce = w;
      bus.wd  = 32'hDEADBEEF;
      bus.rce = r;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      bus.wce  = 1'b0;
      bus.rce  = 1'b0;
      sb.delete();
      lvl_m    = 0;
      ovf_m    = 1'b0;
      udf_m    = 1'b0;
      rvalid_m = 1'b0;
      rq_m     = 8'h00;
      check_all();
   endtask

   initial begin
      bus.wce = 1'b0;
      bus.wd  = '0;
      bus.rce = 1'b0;

      // 1: single word, little-endian byte order
      do_reset(1'b0, 1'b0);
      step(1'b1, 32'h44332211, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
      check("t1_last_byte", 32'(bus.rq), 32'h44);
      step(1'b0, 32'h0, 1'b0);

      // 2: fill to capacity, overflow, then drain
      for (int i = 0; i < 1024; i++) step(1'b1, 32'(i * 32'h01010101 + 32'h00010203), 1'b0);
      check("t2_level_full", 32'(bus.level), 32'd4096);
      step(1'b1, 32'hCAFEF00D, 1'b0);
      check("t2_ovf", 32'(bus.ovf), 32'd1);
      check("t2_level_held", 32'(bus.level), 32'd4096);
      for (int i = 0; i < RD_DEPTH; i++) step(1'b0, 32'h0, 1'b1);

      // 3: pop from empty
      step(1'b0, 32'h0, 1'b1);
      check("t3_udf", 32'(bus.udf), 32'd1);

      // 4: level 4 then simultaneous push/pop
      step(1'b1, 32'hA3A2A1A0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 32'h10101010 * (i + 1) + 32'h03020100, 1'b1);
      check("t4_level", 32'(bus.level), 32'd31);
      while (lvl_m > 0) step(1'b0, 32'h0, 1'b1);

      // 5: interleaved stream wrapping both pointers, then a random mix
      for (int i = 0; i < 12000; i++) step((i % 4) == 0, $urandom, 1'b1);
      for (int i = 0; i < 4000; i++) begin
         if (i < 2500) step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
         else          step($urandom_range(0, 3) == 0, $urandom, 1'b1);
      end
      while (lvl_m > 0) step(1'b0, 32'h0, 1'b1);

      // 6: reset mid-stream with push and pop requested
      for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
      check("t6_level_pre", 32'(bus.level), 32'd37);
      do_reset(1'b1, 1'b1);
      check("t6_level_post", 32'(bus.level), 32'd0);
      step(1'b1, 32'hDDCCBBAA, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      check("t6_first_byte", 32'(bus.rq), 32'hAA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
